cpu_core: RTL and testbench

Parametrised successor of the fixed 8-bit two-register CPU. It holds the full datapath and control FSM in one module: PC, IR, MAR, A, B and CCR registers, an ALU, and a fetch/decode/execute controller. Data width and address width are configurable, and the memory port has a request/ready handshake that tolerates wait states. It sits between the system memory model and the top level, replacing the fixed-width `cpu`.

---
 rtl/cpu_mem_if.sv | 16 +
 rtl/cpu_core.sv | 139 +++++++++++++
 tb/tb_cpu_core.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_if.sv
// Memory port of cpu_core: request/ready handshake with wait-state tolerance.
// The core drives the master side and the memory model drives the slave side.
interface cpu_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] from_memory;
    logic [DATA_W-1:0] to_memory;
    logic [ADDR_W-1:0] address;
    logic              mem_ready;
    logic              write;
    logic              mem_req;

    modport master (input from_memory, mem_ready, output to_memory, address, write, mem_req);
    modport slave  (output from_memory, mem_ready, input to_memory, address, write, mem_req);
endinterface

// File: rtl/cpu_core.sv
// Parametrised two-register CPU: PC/IR/MAR/A/B/CCR datapath, ALU and a
// fetch/decode/operand/memory/execute controller on a ready-handshake memory port.
module cpu_core #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_if.master         mem,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_b,
    output logic [3:0]        dbg_ccr
);
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_MEMORY  = 3'd3;
    localparam logic [2:0] S_EXECUTE = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam int M = DATA_W - 1;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc, r_mar;
    logic [7:0]        r_ir;  // only the opcode byte of IR is ever observed
    logic [DATA_W-1:0] r_a, r_b;
    logic [3:0]        r_ccr;

    logic              w_is_alu, w_is_imm, w_is_dir, w_is_br, w_is_store, w_to_b, w_taken;
    logic              w_sub, w_v, w_c, w_wr;
    logic [DATA_W-1:0] w_opnd, w_res;
    logic [DATA_W:0]   w_sum;
    logic [3:0]        w_ccr;

    assign w_is_alu   = r_ir inside {[8'h42:8'h47]};
    assign w_is_imm   = r_ir inside {8'h86, 8'h88};
    assign w_is_dir   = r_ir inside {8'h87, 8'h89, 8'h96, 8'h97};
    assign w_is_br    = r_ir inside {[8'h20:8'h23]};
    assign w_is_store = r_ir inside {8'h96, 8'h97};
    assign w_to_b     = r_ir inside {8'h88, 8'h89, 8'h97};

    always_comb begin
        case (r_ir)
            8'h20:   w_taken = 1'b1;
            8'h21:   w_taken = r_ccr[2];
            8'h22:   w_taken = ~r_ccr[2];
            8'h23:   w_taken = r_ccr[0];
            default: w_taken = 1'b0;
        endcase
    end

    // One adder serves ADD/SUB/INCA/DECA; bit DATA_W is carry, or borrow on subtract.
    always_comb begin
        w_opnd = (r_ir == 8'h46 || r_ir == 8'h47) ? DATA_W'(1) : r_b;
        w_sub  = (r_ir == 8'h43 || r_ir == 8'h47);
        w_sum  = w_sub ? ({1'b0, r_a} - {1'b0, w_opnd}) : ({1'b0, r_a} + {1'b0, w_opnd});
        w_res  = w_sum[M:0];
        w_c    = w_sum[DATA_W];
        w_v    = w_sub ? ((r_a[M] != w_opnd[M]) && (w_res[M] != r_a[M]))
                       : ((r_a[M] == w_opnd[M]) && (w_res[M] != r_a[M]));
        if (r_ir == 8'h44 || r_ir == 8'h45) begin
            w_res = (r_ir == 8'h44) ? (r_a & r_b) : (r_a | r_b);
            w_c   = 1'b0;
            w_v   = 1'b0;
        end
    end
    assign w_ccr = {w_res[M], (w_res == '0), w_v, w_c};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= ADDR_W'(RESET_PC);
            r_ir    <= '0;
            r_mar   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ccr   <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem.mem_ready) begin
                    r_ir    <= mem.from_memory[7:0];
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_is_alu)                       r_state <= S_EXECUTE;
                    else if (w_is_imm || w_is_dir || w_is_br) r_state <= S_OPERAND;
                    else if (r_ir == 8'hFF)             r_state <= S_HALT;
                    else                                r_state <= S_FETCH;
                end
                S_OPERAND: if (mem.mem_ready) begin
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= S_FETCH;
                    if (w_is_imm) begin
                        if (w_to_b) r_b <= mem.from_memory;
                        else        r_a <= mem.from_memory;
                    end else if (w_is_dir) begin
                        r_mar   <= mem.from_memory[ADDR_W-1:0];
                        r_state <= S_MEMORY;
                    end else if (w_taken) begin
                        r_pc    <= mem.from_memory[ADDR_W-1:0];
                    end
                end
                S_MEMORY: if (mem.mem_ready) begin
                    if (!w_is_store) begin
                        if (w_to_b) r_b <= mem.from_memory;
                        else        r_a <= mem.from_memory;
                    end
                    r_state <= S_FETCH;
                end
                S_EXECUTE: begin
                    r_a     <= w_res;
                    r_ccr   <= w_ccr;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Bus outputs decode registered state only, so a held request stays stable.
    assign w_wr = (r_state == S_MEMORY) && w_is_store;
    always_comb begin
        mem.mem_req   = (r_state == S_FETCH) || (r_state == S_OPERAND) || (r_state == S_MEMORY);
        mem.address   = (r_state == S_MEMORY) ? r_mar : r_pc;
        mem.write     = w_wr;
        mem.to_memory = w_wr ? (w_to_b ? r_b : r_a) : '0;
    end

    assign halted  = (r_state == S_HALT);
    assign dbg_pc  = r_pc;
    assign dbg_a   = r_a;
    assign dbg_b   = r_b;
    assign dbg_ccr = r_ccr;
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: 8/8 and 16/12 instances, directed vectors, wait-state and
// reset corner cases, and random programs checked against an instruction-level model.
module tb_cpu_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst16;
    cpu_mem_if #(.DATA_W(8),  .ADDR_W(8))  m8();
    cpu_mem_if #(.DATA_W(16), .ADDR_W(12)) m16();

    logic        halt8, halt16;
    logic [7:0]  pc8, a8, b8;
    logic [3:0]  ccr8, ccr16;
    logic [11:0] pc16;
    logic [15:0] a16, b16;

    cpu_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut8 (
        .clk(clk), .reset(rst8), .mem(m8.master), .halted(halt8),
        .dbg_pc(pc8), .dbg_a(a8), .dbg_b(b8), .dbg_ccr(ccr8));
    cpu_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(0)) dut16 (
        .clk(clk), .reset(rst16), .mem(m16.master), .halted(halt16),
        .dbg_pc(pc16), .dbg_a(a16), .dbg_b(b16), .dbg_ccr(ccr16));

    logic [7:0]  mem8 [256];
    logic [15:0] mem16[4096];
    logic [7:0]  mm   [256];

    int wait_n   = 0;
    bit rnd_mode = 1'b0;
    int wcnt;
    bit rbit;

    assign m8.from_memory  = mem8[m8.address];
    assign m16.from_memory = mem16[m16.address];
    assign m16.mem_ready   = 1'b1;
    assign m8.mem_ready    = rnd_mode ? rbit : (wcnt >= wait_n);

    always @(posedge clk or negedge rst8)
        if (!rst8) wcnt <= 0;
        else if (m8.mem_req) wcnt <= m8.mem_ready ? 0 : wcnt + 1;
    always @(posedge clk) rbit <= ($urandom_range(0, 99) < 65);
    always @(posedge clk) if (rst8 && m8.mem_req && m8.mem_ready && m8.write) mem8[m8.address] = m8.to_memory;
    always @(posedge clk) if (rst16 && m16.mem_req && m16.write) mem16[m16.address] = m16.to_memory;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic rel8();
        @(posedge clk); #1;
        @(negedge clk);
        rst8 = 1'b1;
    endtask

    // Counts rising edges until halted; any request not accepted must hold its outputs.
    task automatic run8(input int maxc, output int cyc);
        logic [17:0] snap;
        bit hold;
        cyc = 0;
        forever begin
            hold = m8.mem_req && !m8.mem_ready;
            snap = {m8.mem_req, m8.write, m8.address, m8.to_memory};
            @(posedge clk); #1;
            cyc++;
            if (hold) chk("hold", 32'({m8.mem_req, m8.write, m8.address, m8.to_memory}), 32'(snap));
            if (halt8) break;
            if (cyc >= maxc) begin
                errors++;
                $display("FAIL run_timeout actual=%0d cycles expected=halted", cyc);
                break;
            end
        end
    endtask

    function automatic int sg(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    int m_a, m_b, m_pc;
    logic [3:0] m_ccr;

    // Instruction-level reference: executes mm[] directly, returns cycles at ready=1.
    task automatic model_run(output bit ok, output int cyc);
        int pc, a, b, op, opd, k, r, sv;
        bit n, z, v, c, tk;
        pc = 0; a = 0; b = 0; n = 0; z = 0; v = 0; c = 0; ok = 0; cyc = 0; opd = 0;
        for (int s = 0; s < 400; s++) begin
            op = int'(mm[pc]); pc = (pc + 1) % 256;
            if (op == 'hFF) begin cyc += 2; ok = 1; break; end
            if (op inside {'h86, 'h87, 'h88, 'h89, 'h96, 'h97, 'h20, 'h21, 'h22, 'h23}) begin
                opd = int'(mm[pc]); pc = (pc + 1) % 256;
            end
            case (op)
                'h86: begin a = opd; cyc += 3; end
                'h88: begin b = opd; cyc += 3; end
                'h87: begin a = int'(mm[opd]); cyc += 4; end
                'h89: begin b = int'(mm[opd]); cyc += 4; end
                'h96: begin mm[opd] = 8'(a); cyc += 4; end
                'h97: begin mm[opd] = 8'(b); cyc += 4; end
                'h20, 'h21, 'h22, 'h23: begin
                    tk = (op == 'h20) || (op == 'h21 && z) || (op == 'h22 && !z) || (op == 'h23 && c);
                    if (tk) pc = opd;
                    cyc += 3;
                end
                'h42, 'h46: begin
                    k = (op == 'h42) ? b : 1;
                    r = a + k; c = (r > 255); sv = sg(a) + sg(k);
                    v = (sv > 127) || (sv < -128); a = r % 256; cyc += 3;
                end
                'h43, 'h47: begin
                    k = (op == 'h43) ? b : 1;
                    c = (a < k); sv = sg(a) - sg(k);
                    v = (sv > 127) || (sv < -128); a = (a - k + 256) % 256; cyc += 3;
                end
                'h44: begin a = a & b; v = 0; c = 0; cyc += 3; end
                'h45: begin a = a | b; v = 0; c = 0; cyc += 3; end
                default: cyc += 2;
            endcase
            if (op inside {['h42:'h47]}) begin n = (a > 127); z = (a == 0); end
        end
        m_a = a; m_b = b; m_pc = pc; m_ccr = {n, z, v, c};
    endtask

    typedef struct {
        logic [0:9][7:0] prog;
        logic [7:0]      a;
        logic [3:0]      ccr;
        logic [7:0]      pc;
        int              cyc;
    } vec_t;
    vec_t vecs[14];

    int ops[18] = '{'h86, 'h87, 'h88, 'h89, 'h96, 'h97, 'h42, 'h43, 'h44,
                    'h45, 'h46, 'h47, 'h20, 'h21, 'h22, 'h23, 'h00, 'h55};

    initial begin
        int cyc, mcyc, pos, op, nbad;
        bit ok;
        rst8 = 1'b0; rst16 = 1'b0;

        vecs[0]  = '{80'h867F880142FF00000000, 8'h80, 4'hA, 8'h06, 11};
        vecs[1]  = '{80'h86FF880142FF00000000, 8'h00, 4'h5, 8'h06, 11};
        vecs[2]  = '{80'h8603880543FF00000000, 8'hFE, 4'h9, 8'h06, 11};
        vecs[3]  = '{80'h86FF8801422140FF0000, 8'h00, 4'h5, 8'h41, 14};
        vecs[4]  = '{80'h86012140FF0000000000, 8'h01, 4'h0, 8'h05, 8};
        vecs[5]  = '{80'h86038805432340FF0000, 8'hFE, 4'h9, 8'h41, 14};
        vecs[6]  = '{80'h558609FF000000000000, 8'h09, 4'h0, 8'h04, 7};
        vecs[7]  = '{80'h86FF880142888045FF00, 8'h80, 4'h8, 8'h09, 17};
        vecs[8]  = '{80'h860047FF000000000000, 8'hFF, 4'h9, 8'h04, 8};
        vecs[9]  = '{80'h867F46FF000000000000, 8'h80, 4'hA, 8'h04, 8};
        vecs[10] = '{80'h885A97908790FF000000, 8'h5A, 4'h0, 8'h07, 13};
        vecs[11] = '{80'h86F0883C44FF00000000, 8'h30, 4'h0, 8'h06, 11};
        vecs[12] = '{80'h86012240000000000000, 8'h01, 4'h0, 8'h41, 8};
        vecs[13] = '{80'h20400000000000000000, 8'h00, 4'h0, 8'h41, 5};

        // Reset state and the reference program at 8/8.
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        {mem8[0], mem8[1], mem8[2], mem8[3]} = 32'h86058803;
        {mem8[4], mem8[5], mem8[6], mem8[7]} = 32'h429680FF;
        @(posedge clk); #1;
        chk("rst_addr", 32'(m8.address), 0);
        chk("rst_req_wr_halt", {29'd0, m8.mem_req, m8.write, halt8}, 32'b100);
        chk("rst_tomem", 32'(m8.to_memory), 0);
        chk("rst_regs", {a8, b8, pc8, 4'h0, ccr8}, 0);
        @(negedge clk); rst8 = 1'b1;
        run8(200, cyc);
        chk("t1_cycles", cyc, 15);
        chk("t1_mem80", 32'(mem8[8'h80]), 32'h08);
        chk("t1_ccr", 32'(ccr8), 0);
        chk("t1_pc", 32'(pc8), 32'h08);

        // Same program with three wait cycles on every transaction (9 transactions).
        rst8 = 1'b0; mem8[8'h80] = 8'h00; wait_n = 3;
        rel8();
        run8(400, cyc);
        chk("ws_cycles", cyc, 15 + 9 * 3);
        chk("ws_mem80", 32'(mem8[8'h80]), 32'h08);

        // Reset while the STA write is being held off by ready=0.
        rst8 = 1'b0; mem8[8'h80] = 8'hEE;
        rel8();
        cyc = 0;
        while (!(m8.write === 1'b1) && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("mid_write_seen", {30'd0, m8.write, m8.mem_ready}, 32'b10);
        rst8 = 1'b0; #1;
        chk("mid_write_drop", {30'd0, m8.write, m8.mem_req}, 32'b01);
        chk("mid_tomem_drop", 32'(m8.to_memory), 0);
        chk("mid_addr_reset", 32'(m8.address), 0);
        @(posedge clk); #1;
        chk("mid_mem_kept", 32'(mem8[8'h80]), 32'hEE);
        @(negedge clk); rst8 = 1'b1;
        run8(400, cyc);
        chk("mid_rerun_cycles", cyc, 42);
        chk("mid_rerun_mem", 32'(mem8[8'h80]), 32'h08);
        wait_n = 0;

        // Directed vectors.
        for (int v = 0; v < 14; v++) begin
            rst8 = 1'b0;
            for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
            mem8[8'h40] = 8'hFF;
            for (int i = 0; i < 10; i++) mem8[i] = vecs[v].prog[i];
            rel8();
            run8(300, cyc);
            chk($sformatf("vec%0d_a", v), 32'(a8), 32'(vecs[v].a));
            chk($sformatf("vec%0d_ccr", v), 32'(ccr8), 32'(vecs[v].ccr));
            chk($sformatf("vec%0d_pc", v), 32'(pc8), 32'(vecs[v].pc));
            chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].cyc);
        end

        // PC wrap: BRA 0xFF onto a NOP, next fetch must be at 0x00.
        rst8 = 1'b0;
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        mem8[0] = 8'h20; mem8[1] = 8'hFF;
        rel8();
        repeat (3) @(posedge clk); #1;
        chk("wrap_fetch_ff", {23'd0, m8.mem_req, m8.address}, {23'd0, 1'b1, 8'hFF});
        repeat (2) @(posedge clk); #1;
        chk("wrap_fetch_00", {23'd0, m8.mem_req, m8.address}, {23'd0, 1'b1, 8'h00});

        // Random programs against the instruction-level model.
        for (int it = 0; it < 40; it++) begin
            rst8 = 1'b0;
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                for (int i = 0; i < 256; i++) mm[i] = 8'hFF;
                for (int i = 'h80; i < 'hA0; i++) mm[i] = 8'($urandom_range(0, 255));
                pos = 0;
                for (int k = 0; k < 12; k++) begin
                    op = ops[$urandom_range(0, 17)];
                    mm[pos] = 8'(op); pos++;
                    if (op inside {'h86, 'h88}) begin mm[pos] = 8'($urandom_range(0, 255)); pos++; end
                    else if (op inside {'h87, 'h89, 'h96, 'h97}) begin mm[pos] = 8'('h80 + $urandom_range(0, 31)); pos++; end
                    else if (op inside {['h20:'h23]}) begin mm[pos] = 8'($urandom_range(0, 40)); pos++; end
                end
                mm[pos] = 8'hFF;
                mem8 = mm;
                model_run(ok, mcyc);
            end
            if (!ok) continue;
            rnd_mode = it[0];
            rel8();
            run8(3000, cyc);
            chk($sformatf("rnd%0d_a", it), 32'(a8), 32'(m_a));
            chk($sformatf("rnd%0d_b", it), 32'(b8), 32'(m_b));
            chk($sformatf("rnd%0d_ccr", it), 32'(ccr8), 32'(m_ccr));
            chk($sformatf("rnd%0d_pc", it), 32'(pc8), 32'(m_pc));
            nbad = 0;
            for (int i = 0; i < 256; i++) if (mem8[i] !== mm[i]) nbad++;
            chk($sformatf("rnd%0d_mem", it), nbad, 0);
            if (!rnd_mode) chk($sformatf("rnd%0d_cycles", it), cyc, mcyc);
        end
        rnd_mode = 1'b0;

        // 16-bit data, 12-bit address: 0x8001 + 0x7FFF.
        for (int i = 0; i < 4096; i++) mem16[i] = 16'h0000;
        mem16[0] = 16'h0086; mem16[1] = 16'h8001; mem16[2] = 16'h0088; mem16[3] = 16'h7FFF;
        mem16[4] = 16'h0042; mem16[5] = 16'h0096; mem16[6] = 16'h0080; mem16[7] = 16'h00FF;
        mem16[12'h080] = 16'hBEEF;
        @(negedge clk); rst16 = 1'b1;
        cyc = 0;
        while (!halt16 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("w16_cycles", cyc, 15);
        chk("w16_a", 32'(a16), 0);
        chk("w16_ccr", 32'(ccr16), 32'h5);
        chk("w16_mem80", 32'(mem16[12'h080]), 0);
        chk("w16_pc", 32'(pc16), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
